// File: rtl/weight_stream_source.sv
// weight_stream_source: loads a BDIM*SDIM weight tile into RAM and replays it num_reps times on an AXI-Stream master.
// Define WEIGHT_STREAM_SOURCE_PERF_EN to add the stall_cycles / beat_count performance counters.
module weight_stream_source #(
   parameter int WIDTH  = 8,
   parameter int BDIM   = 4,
   parameter int SDIM   = 16,
   parameter int ADDR_W = $clog2(BDIM*SDIM),
   parameter int REP_W  = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              start,
   input  logic [REP_W-1:0]  num_reps,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  m_axis_weights_tdata,
   output logic              m_axis_weights_tvalid,
   input  logic              m_axis_weights_tready,
   output logic              m_axis_weights_tlast,
   output logic              m_axis_weights_tuser
`ifdef WEIGHT_STREAM_SOURCE_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       beat_count
`endif
);
   localparam int                DEPTH     = BDIM*SDIM;
   localparam logic [ADDR_W:0]   DEPTH_C   = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH-1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t r_state, w_state_next;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_rd_data;
   logic              r_rd_vld, r_rd_last, r_rd_user, r_rd_fin;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [REP_W-1:0]  r_rep, r_reps;
   logic              r_issue_done;

   logic [WIDTH-1:0]  r_sk_data [2];
   logic [1:0]        r_sk_last, r_sk_user, r_sk_fin;
   logic              r_sk_wp, r_sk_rp;
   logic [1:0]        r_sk_cnt;

   logic              w_start_acc, w_sk_ne, w_pop, w_pop_sk, w_push, w_issue;
   logic              w_last_addr, w_last_rep, w_head_last, w_head_user, w_head_fin;
   logic [1:0]        w_sk_cnt_next;
   logic [WIDTH-1:0]  w_head_data;

   // Output head comes from the skid buffer when it holds data, else straight from the RAM read register.
   assign w_start_acc = (r_state == IDLE) && start;
   assign w_sk_ne     = (r_sk_cnt != 2'd0);
   assign w_head_data = w_sk_ne ? r_sk_data[r_sk_rp] : r_rd_data;
   assign w_head_last = w_sk_ne ? r_sk_last[r_sk_rp] : r_rd_last;
   assign w_head_user = w_sk_ne ? r_sk_user[r_sk_rp] : r_rd_user;
   assign w_head_fin  = w_sk_ne ? r_sk_fin[r_sk_rp]  : r_rd_fin;

   assign m_axis_weights_tvalid = w_sk_ne | r_rd_vld;
   assign m_axis_weights_tdata  = m_axis_weights_tvalid ? w_head_data : '0;
   assign m_axis_weights_tlast  = m_axis_weights_tvalid & w_head_last;
   assign m_axis_weights_tuser  = m_axis_weights_tvalid & w_head_user;

   assign w_pop         = m_axis_weights_tvalid & m_axis_weights_tready;
   assign w_pop_sk      = w_pop & w_sk_ne;
   assign w_push        = r_rd_vld & ~(w_pop & ~w_sk_ne);
   assign w_sk_cnt_next = r_sk_cnt + {1'b0, w_push} - {1'b0, w_pop_sk};
   assign w_last_addr   = (r_rd_addr == ADDR_LAST);
   assign w_last_rep    = (r_rep == r_reps - REP_W'(1));
   // A new read lands in the read register next cycle; it must fit in the skid buffer even if nothing drains.
   assign w_issue       = (r_state == RUN) && !r_issue_done && (w_sk_cnt_next <= 2'd1);

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: if (start) w_state_next = (num_reps != '0) ? RUN : FIN;
         RUN: begin
            busy = 1'b1;
            if (w_pop && w_head_fin) w_state_next = FIN;
         end
         FIN: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (wr_en && (r_state != RUN) && ({1'b0, wr_addr} < DEPTH_C))
         r_mem[wr_addr] <= wr_data;
      if (w_issue)
         r_rd_data <= r_mem[r_rd_addr];
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state      <= IDLE;
         r_rd_vld     <= 1'b0;
         r_rd_last    <= 1'b0;
         r_rd_user    <= 1'b0;
         r_rd_fin     <= 1'b0;
         r_rd_addr    <= '0;
         r_rep        <= '0;
         r_reps       <= '0;
         r_issue_done <= 1'b0;
         for (int i = 0; i < 2; i++) r_sk_data[i] <= '0;
         r_sk_last    <= '0;
         r_sk_user    <= '0;
         r_sk_fin     <= '0;
         r_sk_wp      <= 1'b0;
         r_sk_rp      <= 1'b0;
         r_sk_cnt     <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start_acc) begin
            r_reps       <= num_reps;
            r_rep        <= '0;
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
         end else if (w_issue) begin
            r_rd_addr <= w_last_addr ? '0 : r_rd_addr + ADDR_W'(1);
            if (w_last_addr) begin
               r_rep <= r_rep + REP_W'(1);
               if (w_last_rep) r_issue_done <= 1'b1;
            end
         end
         r_rd_vld <= w_issue;
         if (w_issue) begin
            r_rd_last <= w_last_addr;
            r_rd_user <= ((32'(r_rd_addr) % BDIM) == BDIM - 1);
            r_rd_fin  <= w_last_addr & w_last_rep;
         end
         if (w_push) begin
            r_sk_data[r_sk_wp] <= r_rd_data;
            r_sk_last[r_sk_wp] <= r_rd_last;
            r_sk_user[r_sk_wp] <= r_rd_user;
            r_sk_fin[r_sk_wp]  <= r_rd_fin;
            r_sk_wp            <= ~r_sk_wp;
         end
         if (w_pop_sk) r_sk_rp <= ~r_sk_rp;
         r_sk_cnt <= w_sk_cnt_next;
      end
   end

`ifdef WEIGHT_STREAM_SOURCE_PERF_EN
   logic [31:0] r_stall, r_beats;

   always_ff @(posedge ap_clk) begin
      if (ap_rst || w_start_acc) begin
         r_stall <= '0;
         r_beats <= '0;
      end else begin
         if (m_axis_weights_tvalid && !m_axis_weights_tready && (r_stall != '1)) r_stall <= r_stall + 32'd1;
         if (w_pop && (r_beats != '1)) r_beats <= r_beats + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
   assign beat_count   = r_beats;
`endif
endmodule
